// File: rtl/clk_step_ctrl_if.sv
// clk_step_ctrl_if: groups the CPU-facing signals of the clock-step controller.
//   run_sw     : slide switch, 1 = free-run, 0 = single-step (asynchronous)
//   step_btn   : pushbutton, active-high (asynchronous)
//   halt       : halt request from the CPU, synchronous to sys_clk
//   cpu_en     : one-cycle CPU clock-enable pulse
//   mode_run   : 1 while the controller is in RUN
//   halted     : 1 while the controller is in HALTED
//   step_count : number of cpu_en pulses issued, wraps at 16 bits
// master = board/CPU side, slave = clk_step_ctrl.
interface clk_step_ctrl_if;
  logic        run_sw;
  logic        step_btn;
  logic        halt;
  logic        cpu_en;
  logic        mode_run;
  logic        halted;
  logic [15:0] step_count;

  modport master (
    output run_sw, step_btn, halt,
    input  cpu_en, mode_run, halted, step_count
  );

  modport slave (
    input  run_sw, step_btn, halt,
    output cpu_en, mode_run, halted, step_count
  );
endinterface

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: CPU clock-enable generator. Produces a single-cycle cpu_en
// pulse either at a divided rate (RUN) or once per button press (STEP).
// A CPU halt freezes the block until reset.
// Ports:
//   sys_clk : board clock, single domain
//   reset   : synchronous, active-high
//   bus     : clk_step_ctrl_if.slave (run_sw, step_btn, halt in;
//             cpu_en, mode_run, halted, step_count out)
// Parameters: DIV_MAX (run period - 1), DIV_W, DB_CYCLES (debounce window - 1), DB_W.
// Build option: define CLK_STEP_DEBOUNCE_EN to insert the button debouncer;
// without it the synchronised button is used directly.
//
// state  | meaning
// IDLE   | one cycle after reset, picks RUN or STEP from run_s
// RUN    | free-running divider, pulse after each terminal count
// STEP   | one pulse per debounced button rising edge
// HALTED | CPU halted, no pulses, counters frozen until reset
module clk_step_ctrl #(
  parameter int unsigned          DIV_W     = 26,
  parameter logic [DIV_W-1:0]     DIV_MAX   = 26'd49_999_999,
  parameter int unsigned          DB_W      = 20,
  parameter logic [DB_W-1:0]      DB_CYCLES = 20'd999_999
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  clk_step_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             cpu_en_q, cpu_en_d;
  logic             mode_run_q, halted_q;
  logic [15:0]      step_cnt_q;

  logic run_meta, run_s;
  logic btn_meta, btn_s;
  logic btn_db, btn_db_q, step_req;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      run_meta <= bus.run_sw;
      run_s    <= run_meta;
      btn_meta <= bus.step_btn;
      btn_s    <= btn_meta;
    end
  end

`ifdef CLK_STEP_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt_q;
  logic            btn_db_r;

  // btn_db only follows btn_s after it has disagreed for DB_CYCLES+1 cycles
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      db_cnt_q <= '0;
      btn_db_r <= 1'b0;
    end else if (btn_s == btn_db_r) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_CYCLES) begin
      btn_db_r <= btn_s;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign btn_db = btn_db_r;
`else
  // debounce parameters have no hardware in this build
  logic [DB_W-1:0] unused_db;
  assign unused_db = DB_CYCLES;
  assign btn_db    = btn_s;
`endif

  // registered rising-edge detect; this stage sets the 3-edge step latency
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      btn_db_q <= 1'b0;
      step_req <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      step_req <= btn_db & ~btn_db_q;
    end
  end

  // priority in RUN/STEP: halt, then mode change, then pulse
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    cpu_en_d  = 1'b0;
    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        state_d   = run_s ? RUN : STEP;
      end
      RUN: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (!run_s) begin
          state_d   = STEP;
          div_cnt_d = '0;
        end else if (div_cnt_q == DIV_MAX) begin
          div_cnt_d = '0;
          cpu_en_d  = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      STEP: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (run_s) begin
          state_d   = RUN;
          div_cnt_d = '0;
        end else if (step_req) begin
          cpu_en_d = 1'b1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      cpu_en_q   <= 1'b0;
      mode_run_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      cpu_en_q   <= cpu_en_d;
      mode_run_q <= (state_d == RUN);
      halted_q   <= (state_d == HALTED);
    end
  end

  // counts the pulse at the end of the cycle in which cpu_en is high
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      step_cnt_q <= '0;
    end else if (cpu_en_q) begin
      step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.mode_run   = mode_run_q;
  assign bus.halted     = halted_q;
  assign bus.step_count = step_cnt_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl: directed bench for clk_step_ctrl with DIV_MAX=3, DB_CYCLES=4.
// Stimulus pushes {edge index, step_count} for every pulse it expects; a
// monitor pops on each cpu_en and checks the edge and the following count.
module tb_clk_step_ctrl;

`ifdef CLK_STEP_DEBOUNCE_EN
  localparam int DB_EXTRA = 5;
`else
  localparam int DB_EXTRA = 0;
`endif
  localparam int STEP_LAT = 3 + DB_EXTRA;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } exp_t;

  logic sys_clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt;
  logic [15:0] cnt_exp;
  logic        cnt_pending = 1'b0;

  clk_step_ctrl_if bus ();

  clk_step_ctrl #(
    .DIV_W     (26),
    .DIV_MAX   (26'd3),
    .DB_W      (20),
    .DB_CYCLES (20'd4)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // monitor: every cpu_en must match the head of the expectation queue
  always @(negedge sys_clk) begin
    if (cnt_pending) begin
      n_checks++;
      if (bus.step_count !== cnt_exp) begin
        n_fail++;
        $display("FAIL step_count_after_pulse @%0d: got %h, expected %h", cyc, bus.step_count, cnt_exp);
      end
      cnt_pending = 1'b0;
    end
    if (bus.cpu_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got cpu_en at edge %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL pulse_edge: got edge %0d, expected edge %0d", cyc, e.cyc);
        end
        cnt_exp     = e.cnt;
        cnt_pending = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  task automatic push(input int c, input logic [15:0] cnt);
    exp_t e;
    e.cyc = c;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // clean press: held long enough to pass the debouncer when it is built in
  task automatic press();
    exp_cnt = exp_cnt + 16'd1;
    push(cyc + 1 + STEP_LAT, exp_cnt);
    bus.step_btn = 1'b1;
    tick(3 + DB_EXTRA);
    bus.step_btn = 1'b0;
    tick(7 + DB_EXTRA);
  endtask

  initial begin
    int          c;
    logic [1:0]  st;
    reset        = 1'b1;
    bus.run_sw   = 1'b1;
    bus.step_btn = 1'b0;
    bus.halt     = 1'b0;
    exp_cnt      = 16'd0;

    // reset state
    tick(3);
    chk("reset_cpu_en", int'(bus.cpu_en), 0);
    chk("reset_mode_run", int'(bus.mode_run), 0);
    chk("reset_halted", int'(bus.halted), 0);
    chk("reset_step_count", int'(bus.step_count), 0);

    // run rate: RUN entered 3 edges after release, pulses every 4 edges
    c = cyc;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push(c + 7 + 4 * i, 16'(i + 1));
    exp_cnt = 16'd5;
    tick(2);
    chk("run_entry_before", int'(bus.mode_run), 0);
    tick(1);
    chk("run_entry", int'(bus.mode_run), 1);
    // a press while running must not produce a pulse
    bus.step_btn = 1'b1;
    tick(3 + DB_EXTRA);
    bus.step_btn = 1'b0;

    // run -> step switch after the 5th pulse
    wait_cyc(c + 23);
    bus.run_sw = 1'b0;
    tick(2);
    chk("mode_run_before_switch", int'(bus.mode_run), 1);
    tick(1);
    chk("mode_run_after_switch", int'(bus.mode_run), 0);
    tick(12);

    // three single steps
    for (int i = 0; i < 3; i++) press();
    chk("step_count_after_steps", int'(bus.step_count), 8);

    // back to RUN, reset asserted during the first pulse
    c = cyc;
    bus.run_sw = 1'b1;
    push(c + 7, 16'd0);   // the reset edge clears the count this pulse would add
    wait_cyc(c + 7);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    st = dut.state_q;
    chk("reset_mid_cpu_en", int'(bus.cpu_en), 0);
    chk("reset_mid_mode_run", int'(bus.mode_run), 0);
    chk("reset_mid_step_count", int'(bus.step_count), 0);
    chk("idle_after_reset", int'(st), 0);
    tick(1);
    st = dut.state_q;
    chk("step_after_idle", int'(st), 2);
    exp_cnt = 16'd1;
    push(c + 15, exp_cnt);
    tick(2);
    chk("rerun_entry", int'(bus.mode_run), 1);

    // halt sampled in the terminal-count cycle suppresses the due pulse
    wait_cyc(c + 18);
    bus.halt = 1'b1;
    tick(1);
    bus.halt = 1'b0;
    chk("halted_set", int'(bus.halted), 1);
    chk("halted_mode_run", int'(bus.mode_run), 0);
    for (int i = 0; i < 10; i++) begin
      bus.step_btn = ~bus.step_btn;
      bus.run_sw   = ~bus.run_sw;
      tick(2);
    end
    bus.step_btn = 1'b0;
    chk("halted_hold", int'(bus.halted), 1);
    chk("halted_count_frozen", int'(bus.step_count), 1);

    // step_count wrap from a forced 0xFFFF
    reset      = 1'b1;
    bus.run_sw = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(5);
    force dut.step_cnt_q = 16'hFFFF;
    tick(1);
    release dut.step_cnt_q;
    tick(1);
    chk("preload", int'(bus.step_count), 16'hFFFF);
    exp_cnt = 16'hFFFF;
    press();
    chk("wrap", int'(bus.step_count), 0);

`ifdef CLK_STEP_DEBOUNCE_EN
    // bouncing press: only the final stable rise produces a step
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      bus.step_btn = (i % 2 == 0);
      tick(2);
    end
    exp_cnt = exp_cnt + 16'd1;
    push(c + 9 + STEP_LAT, exp_cnt);
    bus.step_btn = 1'b1;
    tick(10);
    bus.step_btn = 1'b0;
    tick(15);
    chk("debounce_count", int'(bus.step_count), int'(exp_cnt));
`endif

    tick(6 + DB_EXTRA);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_pulse: got no cpu_en, expected one at edge %0d", e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
